// File: rtl/aplic_msi_dispatch_if.sv
// rtl/aplic_msi_dispatch_if.sv - MSI request ingress, AXI-style AW/W/B write channel and status of the MSI dispatcher
interface aplic_msi_dispatch_if #(
  parameter int NR_HARTS  = 4,
  parameter int NR_GUESTS = 2,
  parameter int EIID_W    = 11,
  parameter int ADDR_W    = 64
);
  localparam int HART_LEN  = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1;
  localparam int GUEST_LEN = $clog2(NR_GUESTS + 1);

  logic [ADDR_W-1:0]    msi_base;
  logic                 msi_valid;
  logic                 msi_ready;
  logic [HART_LEN-1:0]  msi_hart;
  logic [GUEST_LEN-1:0] msi_guest;
  logic [EIID_W-1:0]    msi_eiid;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_W-1:0]    aw_addr;
  logic                 w_valid;
  logic                 w_ready;
  logic [31:0]          w_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [1:0]           b_resp;
  logic [7:0]           err_cnt;
  logic                 busy;

  modport master (
    input  msi_base, msi_valid, msi_hart, msi_guest, msi_eiid,
    input  aw_ready, w_ready, b_valid, b_resp,
    output msi_ready, aw_valid, aw_addr, w_valid, w_data, b_ready, err_cnt, busy
  );

  modport slave (
    output msi_base, msi_valid, msi_hart, msi_guest, msi_eiid,
    output aw_ready, w_ready, b_valid, b_resp,
    input  msi_ready, aw_valid, aw_addr, w_valid, w_data, b_ready, err_cnt, busy
  );
endinterface

// File: rtl/aplic_msi_dispatch.sv
// rtl/aplic_msi_dispatch.sv - queues APLIC MSIs and writes them to per-hart IMSIC files over a single-outstanding AW/W/B channel
// Optional bounded resend on B error: define APLIC_MSI_RETRY_EN.
module aplic_msi_dispatch #(
  parameter int NR_HARTS   = 4,
  parameter int NR_GUESTS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int EIID_W     = 11,
  parameter int ADDR_W     = 64,
  parameter int MAX_RETRY  = 3
) (
  input logic               i_clk,
  input logic               ni_rst,
  aplic_msi_dispatch_if.master bus
);
  localparam int HART_LEN  = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1;
  localparam int GUEST_LEN = $clog2(NR_GUESTS + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int ENT_W     = HART_LEN + GUEST_LEN + EIID_W;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

  state_t               state;
  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 ready_en;
  logic                 aw_done, w_done;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          data_q;
  logic [7:0]           err_q;

  logic                 full, empty, target_ok, accept, push, drop, pop;
  logic                 aw_fin, w_fin, b_fire, b_err, b_drop;
  logic [HART_LEN-1:0]  h_hart;
  logic [GUEST_LEN-1:0] h_guest;
  logic [EIID_W-1:0]    h_eiid;
  logic [ADDR_W-1:0]    next_addr;
  logic [8:0]           err_sum;

  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign target_ok = (32'(bus.msi_hart) < NR_HARTS) && (32'(bus.msi_guest) <= NR_GUESTS);
  assign accept    = bus.msi_valid & bus.msi_ready;
  assign push      = accept & target_ok;
  assign drop      = accept & ~target_ok;
  assign pop       = (state == IDLE) & ~empty;

  assign {h_hart, h_guest, h_eiid} = mem[rd_ptr];
  // Each hart owns a block of 2^GUEST_LEN consecutive 4 KiB interrupt files.
  assign next_addr = bus.msi_base
                   + (ADDR_W'(h_hart) << (12 + GUEST_LEN))
                   + (ADDR_W'(h_guest) << 12);

  assign aw_fin = aw_done | (bus.aw_valid & bus.aw_ready);
  assign w_fin  = w_done  | (bus.w_valid & bus.w_ready);
  assign b_fire = bus.b_valid & bus.b_ready;
  assign b_err  = b_fire & (bus.b_resp >= 2'd2);

`ifdef APLIC_MSI_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retries;
  assign b_drop = b_err & (retries >= RETRY_W'(MAX_RETRY));
`else
  assign b_drop = b_err;
`endif

  assign err_sum = {1'b0, err_q} + 9'(drop) + 9'(b_drop);

  assign bus.msi_ready = ready_en & ~full;
  assign bus.aw_addr   = addr_q;
  assign bus.w_data    = data_q;
  assign bus.err_cnt   = err_q;
  assign bus.busy      = ~empty | (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {bus.msi_hart, bus.msi_guest, bus.msi_eiid};
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
      err_q    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state        <= IDLE;
      bus.aw_valid <= 1'b0;
      bus.w_valid  <= 1'b0;
      bus.b_ready  <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
`ifdef APLIC_MSI_RETRY_EN
      retries      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            addr_q       <= next_addr;
            data_q       <= 32'(h_eiid);
            bus.aw_valid <= 1'b1;
            bus.w_valid  <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
`ifdef APLIC_MSI_RETRY_EN
            retries      <= '0;
`endif
            state        <= SEND;
          end
        end
        SEND: begin
          if (bus.aw_valid && bus.aw_ready) begin
            bus.aw_valid <= 1'b0;
            aw_done      <= 1'b1;
          end
          if (bus.w_valid && bus.w_ready) begin
            bus.w_valid <= 1'b0;
            w_done      <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bus.b_ready <= 1'b1;
            state       <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (b_fire) begin
            bus.b_ready <= 1'b0;
            state       <= IDLE;
`ifdef APLIC_MSI_RETRY_EN
            // Resend the held message unchanged while retry budget remains.
            if (b_err && !b_drop) begin
              retries      <= retries + 1'b1;
              bus.aw_valid <= 1'b1;
              bus.w_valid  <= 1'b1;
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
              state        <= SEND;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aplic_msi_dispatch.sv
// tb/tb_aplic_msi_dispatch.sv - randomized bench for aplic_msi_dispatch against a queue-based delivery model
module tb_aplic_msi_dispatch;
  localparam int NR_HARTS   = 4;
  localparam int NR_GUESTS  = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int EIID_W     = 11;
  localparam int ADDR_W     = 64;
  localparam int MAX_RETRY  = 3;
  localparam int HART_LEN   = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1;
  localparam int GUEST_LEN  = $clog2(NR_GUESTS + 1);
`ifdef APLIC_MSI_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  aplic_msi_dispatch_if #(.NR_HARTS(NR_HARTS), .NR_GUESTS(NR_GUESTS), .EIID_W(EIID_W), .ADDR_W(ADDR_W)) bus ();

  aplic_msi_dispatch #(
    .NR_HARTS(NR_HARTS), .NR_GUESTS(NR_GUESTS), .FIFO_DEPTH(FIFO_DEPTH),
    .EIID_W(EIID_W), .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk (clk),
    .ni_rst(rst_n),
    .bus   (bus.master)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } msg_t;
  typedef struct { int hart; int guest; int eiid; } req_t;

  msg_t       exp_q[$];
  req_t       reqs[$];
  logic [1:0] resp_q[$];

  int tests = 0, fails = 0;
  int model_err = 0, attempts = 0;
  int aw_beats = 0, w_beats = 0, accepted = 0;
  int aw_pct = 100, w_pct = 100, b_pct = 100, err_pct = 0;
  bit aw_seen = 0, w_seen = 0;
  bit f_in = 0, f_aw = 0, f_w = 0, f_b = 0;
  bit aw_stall = 0, w_stall = 0;
  req_t f_req;
  logic [1:0]        f_resp;
  logic [ADDR_W-1:0] f_addr, prev_addr, last_aw_addr;
  logic [31:0]       f_data, prev_data, last_w_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Fold in the handshakes that happened on the posedge just passed.
  task automatic apply();
    msg_t m;
    if (f_b) begin
      chk("b_after_aw_w", 64'(aw_seen && w_seen), 1);
      if (f_resp < 2'd2) begin
        void'(exp_q.pop_front());
        attempts = 0;
      end else begin
        attempts++;
        if (!RETRY || attempts > MAX_RETRY) begin
          void'(exp_q.pop_front());
          attempts = 0;
          model_err = sat(model_err + 1);
        end
      end
      aw_seen = 0;
      w_seen  = 0;
    end
    if (f_aw) begin
      aw_beats++;
      chk("aw_once", 64'(aw_seen), 0);
      chk("aw_has_msg", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("aw_addr", f_addr, exp_q[0].addr);
      aw_seen = 1;
      last_aw_addr = f_addr;
    end
    if (f_w) begin
      w_beats++;
      chk("w_once", 64'(w_seen), 0);
      chk("w_has_msg", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("w_data", 64'(f_data), 64'(exp_q[0].data));
      w_seen = 1;
      last_w_data = f_data;
    end
    if (f_in) begin
      accepted++;
      void'(reqs.pop_front());
      if (f_req.hart < NR_HARTS && f_req.guest <= NR_GUESTS) begin
        m.addr = bus.msi_base + 64'(f_req.hart) * (64'd1 << (12 + GUEST_LEN)) + 64'(f_req.guest) * 64'h1000;
        m.data = 32'(f_req.eiid);
        exp_q.push_back(m);
      end else begin
        model_err = sat(model_err + 1);
      end
    end
  endtask

  task automatic check();
    chk("err_cnt", 64'(bus.err_cnt), 64'(model_err));
    chk("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
    chk("aw_valid_no_msg", 64'(bus.aw_valid && exp_q.size() == 0), 0);
    chk("aw_repeat", 64'(bus.aw_valid && aw_seen), 0);
    chk("w_repeat", 64'(bus.w_valid && w_seen), 0);
    if (aw_stall) begin
      chk("aw_hold", 64'(bus.aw_valid), 1);
      chk("aw_addr_stable", bus.aw_addr, prev_addr);
    end
    if (w_stall) begin
      chk("w_hold", 64'(bus.w_valid), 1);
      chk("w_data_stable", 64'(bus.w_data), 64'(prev_data));
    end
  endtask

  task automatic drive();
    bus.msi_valid = (reqs.size() != 0);
    if (reqs.size() != 0) begin
      bus.msi_hart  = HART_LEN'(reqs[0].hart);
      bus.msi_guest = GUEST_LEN'(reqs[0].guest);
      bus.msi_eiid  = EIID_W'(reqs[0].eiid);
    end
    bus.aw_ready = ($urandom_range(99) < aw_pct);
    bus.w_ready  = ($urandom_range(99) < w_pct);
    if (!(bus.b_valid && !f_b)) begin
      bus.b_valid = aw_seen && w_seen && ($urandom_range(99) < b_pct);
      if (bus.b_valid) begin
        if (resp_q.size() != 0) bus.b_resp = resp_q.pop_front();
        else if ($urandom_range(99) < err_pct) bus.b_resp = 2'(2 + $urandom_range(1));
        else bus.b_resp = 2'($urandom_range(1));
      end
    end
  endtask

  task automatic sample();
    f_in = bus.msi_valid && bus.msi_ready;
    if (reqs.size() != 0) f_req = reqs[0];
    f_aw = bus.aw_valid && bus.aw_ready;
    f_w  = bus.w_valid && bus.w_ready;
    f_b  = bus.b_valid && bus.b_ready;
    f_addr = bus.aw_addr;
    f_data = bus.w_data;
    f_resp = bus.b_resp;
    aw_stall = bus.aw_valid && !bus.aw_ready;
    w_stall  = bus.w_valid && !bus.w_ready;
    prev_addr = bus.aw_addr;
    prev_data = bus.w_data;
  endtask

  task automatic step();
    @(negedge clk);
    apply();
    check();
    drive();
    sample();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((reqs.size() != 0 || exp_q.size() != 0 || bus.busy) && n < limit) begin
      step();
      n++;
    end
    chk("drain_in_time", 64'(n < limit), 1);
  endtask

  task automatic add_req(input int h, input int g, input int e);
    req_t r;
    r.hart = h; r.guest = g; r.eiid = e;
    reqs.push_back(r);
  endtask

  initial begin
    int a0, e0, acc0, w0;
    bus.msi_base = 64'h2800_0000;
    bus.msi_valid = 0; bus.msi_hart = '0; bus.msi_guest = '0; bus.msi_eiid = '0;
    bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0; bus.b_resp = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_msi_ready", 64'(bus.msi_ready), 0);
    chk("rst_aw_valid", 64'(bus.aw_valid), 0);
    chk("rst_w_valid", 64'(bus.w_valid), 0);
    chk("rst_b_ready", 64'(bus.b_ready), 0);
    chk("rst_err_cnt", 64'(bus.err_cnt), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 64'(bus.msi_ready), 1);

    // Single MSI with every ready high
    add_req(2, 1, 32'h2A);
    step();
    steps(4);
    chk("single_busy_done", 64'(bus.busy), 0);
    chk("single_aw_addr", last_aw_addr, 64'h2800_9000);
    chk("single_w_data", 64'(last_w_data), 64'h2A);

    // AW back-pressure while W completes
    a0 = aw_beats; w0 = w_beats;
    aw_pct = 0;
    add_req(1, 2, 32'h155);
    steps(7);
    chk("bp_w_beats", 64'(w_beats - w0), 1);
    chk("bp_aw_beats", 64'(aw_beats - a0), 0);
    aw_pct = 100;
    drain(200);
    chk("bp_aw_after", 64'(aw_beats - a0), 1);
    chk("bp_w_after", 64'(w_beats - w0), 1);

    // Fill: 6 back-to-back requests against a stalled AW
    acc0 = accepted;
    aw_pct = 0;
    for (int i = 0; i < 6; i++) add_req(i % NR_HARTS, i % (NR_GUESTS + 1), 16 + i);
    steps(10);
    chk("fill_accepted", 64'(accepted - acc0), 5);
    chk("fill_ready_low", 64'(bus.msi_ready), 0);
    aw_pct = 100;
    drain(300);
    chk("fill_all_accepted", 64'(accepted - acc0), 6);

    // Invalid target is swallowed and counted
    e0 = model_err; a0 = aw_beats;
    add_req(0, 3, 7);
    steps(4);
    chk("inv_err_cnt", 64'(bus.err_cnt), 64'(e0 + 1));
    chk("inv_no_aw", 64'(aw_beats - a0), 0);
    chk("inv_not_busy", 64'(bus.busy), 0);

    // B error handling
    e0 = model_err; a0 = aw_beats;
`ifdef APLIC_MSI_RETRY_EN
    resp_q.push_back(2'd2); resp_q.push_back(2'd3); resp_q.push_back(2'd2); resp_q.push_back(2'd2);
    add_req(3, 0, 99);
    drain(300);
    chk("retry4_pairs", 64'(aw_beats - a0), 4);
    chk("retry4_err", 64'(bus.err_cnt), 64'(e0 + 1));
    e0 = model_err; a0 = aw_beats;
    resp_q.push_back(2'd2); resp_q.push_back(2'd0);
    add_req(1, 1, 100);
    drain(300);
    chk("retry_ok_pairs", 64'(aw_beats - a0), 2);
    chk("retry_ok_err", 64'(bus.err_cnt), 64'(e0));
`else
    resp_q.push_back(2'd2);
    add_req(3, 0, 99);
    add_req(0, 2, 100);
    drain(300);
    chk("berr_pairs", 64'(aw_beats - a0), 2);
    chk("berr_err", 64'(bus.err_cnt), 64'(e0 + 1));
    chk("berr_next_sent", 64'(last_w_data), 64'd100);
`endif

    // Reset while waiting for B with two requests queued
    b_pct = 0;
    add_req(0, 0, 1); add_req(1, 0, 2); add_req(2, 0, 3);
    steps(7);
    chk("pre_rst_b_ready", 64'(bus.b_ready), 1);
    chk("pre_rst_queued", 64'(exp_q.size()), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_aw_valid", 64'(bus.aw_valid), 0);
    chk("mid_rst_w_valid", 64'(bus.w_valid), 0);
    chk("mid_rst_b_ready", 64'(bus.b_ready), 0);
    chk("mid_rst_msi_ready", 64'(bus.msi_ready), 0);
    exp_q.delete(); reqs.delete(); resp_q.delete();
    model_err = 0; attempts = 0; aw_seen = 0; w_seen = 0;
    f_in = 0; f_aw = 0; f_w = 0; f_b = 0; aw_stall = 0; w_stall = 0;
    bus.msi_valid = 0; bus.b_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    steps(2);
    chk("post_rst_busy", 64'(bus.busy), 0);
    chk("post_rst_err", 64'(bus.err_cnt), 0);

    // Randomized traffic
    bus.msi_base = {$urandom, 20'h0, 12'h000};
    aw_pct = 60; w_pct = 60; b_pct = 70; err_pct = 25;
    for (int i = 0; i < 400; i++)
      add_req($urandom_range(NR_HARTS - 1), $urandom_range(3), $urandom_range((1 << EIID_W) - 1));
    drain(20000);

    // Error counter saturation
    err_pct = 0;
    for (int i = 0; i < 270; i++) add_req($urandom_range(NR_HARTS - 1), 3, i);
    drain(2000);
    chk("err_saturated", 64'(bus.err_cnt), 64'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
